// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// After reset it zero-fills every word before any requester is granted.
module dm_arbiter #(
  parameter int AW             = 5,
  parameter int DW             = 32,
  parameter int DEPTH          = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          busy,
  output logic [AW-1:0] dm_address,
  output logic [DW-1:0] dm_wd,
  output logic          dm_we,
  input  logic [DW-1:0] dm_rd
);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam state_t        RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
  localparam logic [AW-1:0] LAST_ADDR   = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ADDR_ONE    = AW'(1);
  localparam logic [AW-1:0] ADDR_ZERO   = {AW{1'b0}};
  localparam logic [DW-1:0] DATA_ZERO   = {DW{1'b0}};

  state_t        state_r;
  state_t        state_nxt_s;
  logic [AW-1:0] clr_cnt_r;
  logic          last_r;

  // State register and sweep address counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= RESET_STATE;
      clr_cnt_r <= ADDR_ZERO;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == ST_CLEAR) && (clr_cnt_r != LAST_ADDR)) begin
        clr_cnt_r <= clr_cnt_r + ADDR_ONE;
      end else begin
        clr_cnt_r <= ADDR_ZERO;
      end
    end
  end

  // Next-state: leave the sweep once the final word has been written
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_CLEAR: begin
        if (clr_cnt_r == LAST_ADDR) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      ST_RUN:  state_nxt_s = ST_RUN;
      default: state_nxt_s = RESET_STATE;
    endcase
  end

  // Grants and memory pin mux; a tie goes to the port that was not served last
  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    busy       = 1'b0;
    dm_address = ADDR_ZERO;
    dm_wd      = DATA_ZERO;
    dm_we      = 1'b0;
    case (state_r)
      ST_CLEAR: begin
        busy       = 1'b1;
        dm_address = clr_cnt_r;
        dm_we      = ~reset;
      end
      ST_RUN: begin
        if (!reset) begin
          gnt0 = req0 & (~req1 | last_r);
          gnt1 = req1 & (~req0 | ~last_r);
        end else begin
          gnt0 = 1'b0;
          gnt1 = 1'b0;
        end
        if (gnt0) begin
          dm_address = addr0;
          dm_wd      = wdata0;
          dm_we      = we0;
        end else if (gnt1) begin
          dm_address = addr1;
          dm_wd      = wdata1;
          dm_we      = we1;
        end else begin
          dm_address = ADDR_ZERO;
          dm_wd      = DATA_ZERO;
          dm_we      = 1'b0;
        end
      end
      default: begin
        busy  = 1'b0;
        dm_we = 1'b0;
      end
    endcase
  end

  // Round-robin history: remembers which port was granted most recently
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_r <= 1'b1;
    end else if (gnt0) begin
      last_r <= 1'b0;
    end else if (gnt1) begin
      last_r <= 1'b1;
    end else begin
      last_r <= last_r;
    end
  end

  // Read return registers: capture memory data at the end of a granted read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= DATA_ZERO;
      rdata1  <= DATA_ZERO;
    end else begin
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
      if (gnt0 && !we0) begin
        rdata0 <= dm_rd;
      end
      if (gnt1 && !we1) begin
        rdata1 <= dm_rd;
      end
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Randomized bench for dm_arbiter against a behavioural memory/arbitration model,
// with directed scenarios pinning sweep, RAW, fairness and reset behaviour.
module tb_dm_arbiter;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [4:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, busy, dm_we;
  logic [31:0] rdata0, rdata1, dm_wd, dm_rd;
  logic [4:0]  dm_address;
  logic [31:0] mem [DEPTH];

  // second instance without the clear sweep
  logic        nc_reset, nc_req1, nc_we1;
  logic [4:0]  nc_addr1;
  logic [31:0] nc_wdata1;
  logic        nc_zero_b = 1'b0;
  logic [4:0]  nc_zero_a = 5'd0;
  logic [31:0] nc_zero_d = 32'd0;
  logic        nc_gnt0, nc_gnt1, nc_rvalid0, nc_rvalid1, nc_busy, nc_dm_we;
  logic [31:0] nc_rdata0, nc_rdata1, nc_dm_wd;
  logic [4:0]  nc_dm_address;

  int vectors = 0;
  int miscompares = 0;

  // behavioural model state
  logic [31:0] mem_exp [DEPTH];
  int          clear_left;
  int          tie_winner;
  logic        exp_rv0, exp_rv1;
  logic [31:0] exp_rd0, exp_rd1;
  logic        s_busy, s_gnt0, s_gnt1;

  always #5 clk = ~clk;

  dm_arbiter #(.AW(5), .DW(32), .DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1)) u_dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .dm_address(dm_address), .dm_wd(dm_wd), .dm_we(dm_we), .dm_rd(dm_rd)
  );

  dm_arbiter #(.AW(5), .DW(32), .DEPTH(DEPTH), .CLEAR_ON_RESET(1'b0)) u_dut_nc (
    .clk(clk), .reset(nc_reset),
    .req0(nc_zero_b), .we0(nc_zero_b), .addr0(nc_zero_a), .wdata0(nc_zero_d),
    .req1(nc_req1), .we1(nc_we1), .addr1(nc_addr1), .wdata1(nc_wdata1),
    .gnt0(nc_gnt0), .gnt1(nc_gnt1), .rvalid0(nc_rvalid0), .rvalid1(nc_rvalid1),
    .rdata0(nc_rdata0), .rdata1(nc_rdata1), .busy(nc_busy),
    .dm_address(nc_dm_address), .dm_wd(nc_dm_wd), .dm_we(nc_dm_we), .dm_rd(nc_zero_d)
  );

  // the data memory itself: combinational read, write on the rising edge
  assign dm_rd = mem[dm_address];
  always @(posedge clk) begin
    if (dm_we) mem[dm_address] <= dm_wd;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    clear_left = DEPTH;
    tie_winner = 0;
    exp_rv0 = 1'b0; exp_rv1 = 1'b0;
    exp_rd0 = 32'd0; exp_rd1 = 32'd0;
  endtask

  // compare all outputs against the model, then advance the model past the coming edge
  task automatic compare_and_advance();
    logic eg0, eg1, ewe;
    logic [4:0] ea;
    logic [31:0] ewd;
    if (reset) model_reset();
    eg0 = 1'b0; eg1 = 1'b0; ewe = 1'b0; ea = 5'd0; ewd = 32'd0;
    if (!reset && clear_left > 0) begin
      ewe = 1'b1;
      ea = 5'(DEPTH - clear_left);
    end else if (!reset) begin
      if (req0 && req1) begin
        if (tie_winner == 0) eg0 = 1'b1; else eg1 = 1'b1;
      end else if (req0) eg0 = 1'b1;
      else if (req1) eg1 = 1'b1;
      if (eg0) begin ea = addr0; ewd = wdata0; ewe = we0; end
      else if (eg1) begin ea = addr1; ewd = wdata1; ewe = we1; end
    end
    chk("gnt0", gnt0, eg0);
    chk("gnt1", gnt1, eg1);
    chk("dm_we", dm_we, ewe);
    chk("busy", busy, (reset || clear_left > 0) ? 1'b1 : 1'b0);
    if (!reset) begin
      chk("dm_address", dm_address, ea);
      chk("dm_wd", dm_wd, ewd);
    end
    chk("rvalid0", rvalid0, exp_rv0);
    chk("rvalid1", rvalid1, exp_rv1);
    chk("rdata0", rdata0, exp_rd0);
    chk("rdata1", rdata1, exp_rd1);
    s_busy = busy; s_gnt0 = gnt0; s_gnt1 = gnt1;
    if (!reset) begin
      if (clear_left > 0) begin
        mem_exp[ea] = 32'd0;
        clear_left--;
      end
      exp_rv0 = eg0 && !we0;
      exp_rv1 = eg1 && !we1;
      if (exp_rv0) exp_rd0 = mem_exp[addr0];
      if (exp_rv1) exp_rd1 = mem_exp[addr1];
      if (eg0 && we0) mem_exp[addr0] = wdata0;
      if (eg1 && we1) mem_exp[addr1] = wdata1;
      if (eg0) tie_winner = 1;
      else if (eg1) tie_winner = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_and_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic r, input logic w, input logic [4:0] a, input logic [31:0] d);
    req0 = r; we0 = w; addr0 = a; wdata0 = d;
  endtask

  task automatic set1(input logic r, input logic w, input logic [4:0] a, input logic [31:0] d);
    req1 = r; we1 = w; addr1 = a; wdata1 = d;
  endtask

  task automatic run_sweep(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (!s_busy) break;
      n++;
    end
  endtask

  initial begin
    int n;
    logic [5:0] gseq;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = 32'hDEADBEEF;
      mem_exp[i] = 32'hDEADBEEF;
    end
    model_reset();
    reset = 1'b1;
    nc_reset = 1'b1; nc_req1 = 1'b0; nc_we1 = 1'b0; nc_addr1 = 5'd0; nc_wdata1 = 32'd0;
    set0(1'b1, 1'b0, 5'd5, 32'h0);
    set1(1'b0, 1'b0, 5'd0, 32'h0);
    @(posedge clk); #1;
    step();
    step();

    // sweep with a pending port-0 read of address 5
    reset = 1'b0;
    run_sweep(n);
    chk("sweep_busy_cycles", n, 32'd32);
    chk("first_gnt0", s_gnt0, 1'b1);
    chk("sweep_rvalid0", rvalid0, 1'b1);
    chk("sweep_rdata0", rdata0, 32'h00000000);
    set0(1'b0, 1'b0, 5'd0, 32'h0);

    // single-port write then read
    set0(1'b1, 1'b1, 5'd3, 32'h12345678);
    step();
    chk("wr_gnt0", s_gnt0, 1'b1);
    set0(1'b1, 1'b0, 5'd3, 32'h0);
    step();
    chk("rd_gnt0", s_gnt0, 1'b1);
    chk("rd_rvalid0", rvalid0, 1'b1);
    chk("rd_rdata0", rdata0, 32'h12345678);
    set0(1'b0, 1'b0, 5'd0, 32'h0);

    // port 1 served once so the following tie starts with port 0
    set1(1'b1, 1'b0, 5'd2, 32'h0);
    step();
    set0(1'b1, 1'b0, 5'd1, 32'h0);
    gseq = 6'd0;
    for (int i = 0; i < 6; i++) begin
      step();
      gseq[i] = s_gnt1;
      chk("one_hot_grant", {31'd0, s_gnt0 ^ s_gnt1}, 32'd1);
    end
    chk("fair_sequence", {26'd0, gseq}, {26'd0, 6'b101010});
    set0(1'b0, 1'b0, 5'd0, 32'h0);
    set1(1'b0, 1'b0, 5'd0, 32'h0);

    // cross-port read-after-write
    set1(1'b1, 1'b1, 5'd31, 32'hA5A5A5A5);
    step();
    set1(1'b0, 1'b0, 5'd0, 32'h0);
    set0(1'b1, 1'b0, 5'd31, 32'h0);
    step();
    chk("raw_rdata0", rdata0, 32'hA5A5A5A5);
    set0(1'b0, 1'b0, 5'd0, 32'h0);
    step();

    // randomized traffic with occasional resets
    for (int c = 0; c < 400; c++) begin
      set0($urandom_range(0, 1), $urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom);
      set1($urandom_range(0, 1), $urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom);
      reset = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0;
    set0(1'b0, 1'b0, 5'd0, 32'h0);
    set1(1'b0, 1'b0, 5'd0, 32'h0);
    run_sweep(n);

    // reset arriving mid-write
    set1(1'b1, 1'b1, 5'd7, 32'hFFFFFFFF);
    #2;
    chk("pre_reset_gnt1", gnt1, 1'b1);
    reset = 1'b1;
    #1;
    chk("reset_dm_we", dm_we, 1'b0);
    chk("reset_rvalid", {rvalid0, rvalid1}, 2'b00);
    step();
    set1(1'b0, 1'b0, 5'd0, 32'h0);
    step();
    reset = 1'b0;
    run_sweep(n);
    chk("resweep_busy_cycles", n, 32'd32);
    set0(1'b1, 1'b0, 5'd7, 32'h0);
    step();
    chk("aborted_write_addr7", rdata0, 32'h00000000);
    set0(1'b0, 1'b0, 5'd0, 32'h0);

    // instance without the sweep: request pending across reset release
    nc_req1 = 1'b1; nc_we1 = 1'b1; nc_addr1 = 5'd9; nc_wdata1 = 32'h0BADF00D;
    #1;
    chk("nc_reset_busy", nc_busy, 1'b0);
    chk("nc_reset_gnt1", nc_gnt1, 1'b0);
    step();
    nc_reset = 1'b0;
    #1;
    chk("nc_gnt1", nc_gnt1, 1'b1);
    chk("nc_busy", nc_busy, 1'b0);
    chk("nc_dm_we", nc_dm_we, 1'b1);
    chk("nc_dm_address", nc_dm_address, 5'd9);
    step();
    chk("nc_busy_after", nc_busy, 1'b0);
    nc_req1 = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
